// File: rtl/bias_add_bank_pkg.sv
// rtl/bias_add_bank_pkg.sv - shared sizes, saturation limits and FSM encoding for the bias bank
// Contents:
//   DATA_W, N_adder_tree, N_GROUPS, CNT_W  datapath and counter sizes
//   LANE_W, GRP_W, ADDR_W                  derived index widths
//   SAT_MAX, SAT_MIN                       two's-complement clamp limits
//   state_t                                FSM encoding (IDLE=0, RUN=1, DRAIN=2)
package bias_add_bank_pkg;

   localparam int DATA_W       = 18;
   localparam int N_adder_tree = 16;
   localparam int N_GROUPS     = 4;
   localparam int CNT_W        = 16;

   localparam int LANE_W = $clog2(N_adder_tree);
   localparam int GRP_W  = $clog2(N_GROUPS);
   localparam int ADDR_W = $clog2(N_GROUPS * N_adder_tree);

   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/bias_add_bank_if.sv
// rtl/bias_add_bank_if.sv - input/output beat handshake bundle of the bias bank
// Signals:
//   in_valid, in_ready, in_data              adder-tree sums into the bank
//   out_valid, out_ready, out_data, out_group biased lanes toward the activation buffer
// Modports:
//   master  upstream/downstream side (drives in_*, out_ready)
//   slave   the bias bank itself
interface bias_add_bank_if;
   import bias_add_bank_pkg::*;

   logic                             in_valid;
   logic                             in_ready;
   logic [N_adder_tree*DATA_W-1:0]   in_data;
   logic                             out_valid;
   logic                             out_ready;
   logic [N_adder_tree*DATA_W-1:0]   out_data;
   logic [GRP_W-1:0]                 out_group;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_group
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_group
   );

endinterface

// File: rtl/bias_sat_lane.sv
// rtl/bias_sat_lane.sv - one lane of add bias, saturate, optional ReLU (combinational)
// Ports:
//   sum_in   in   DATA_W  adder-tree sum (two's complement)
//   bias     in   DATA_W  bias for this lane/group
//   relu_en  in   1       clamp negative results to zero
//   result   out  DATA_W  saturated (and optionally rectified) sum
module bias_sat_lane
   import bias_add_bank_pkg::*;
(
   input  logic [DATA_W-1:0] sum_in,
   input  logic [DATA_W-1:0] bias,
   input  logic              relu_en,
   output logic [DATA_W-1:0] result
);

   logic [DATA_W:0]   wide;
   logic [DATA_W-1:0] sat;

   assign wide = {sum_in[DATA_W-1], sum_in} + {bias[DATA_W-1], bias};

   always_comb begin
      sat = wide[DATA_W-1:0];
      // The extra bit disagrees with the sign bit only when the sum left the DATA_W range;
      // the extra bit then carries the true sign and picks the rail.
      if (wide[DATA_W] != wide[DATA_W-1]) begin
         sat = wide[DATA_W] ? SAT_MIN : SAT_MAX;
      end
      result = (relu_en && sat[DATA_W-1]) ? '0 : sat;
   end

endmodule

// File: rtl/bias_add_bank.sv
// rtl/bias_add_bank.sv - run-time loaded bias bank with 1-stage add/saturate/ReLU stream pipeline
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_we/addr/data    bias write port, entry = group*N_adder_tree+lane
//   relu_en             rectify outputs, sampled on every accepted beat
//   num_pix, start      pixel positions per pass, begin pass (IDLE only)
//   done                1-cycle pulse after the final beat leaves (or after an empty pass)
//   bus                 in_*/out_* beat handshake (slave side)
module bias_add_bank
   import bias_add_bank_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              relu_en,
   input  logic [CNT_W-1:0]  num_pix,
   input  logic              start,
   output logic              done,
   bias_add_bank_if.slave    bus
);

   state_t state_q, state_d;
   logic   done_d;

   logic [GRP_W-1:0]  grp_q;
   logic [CNT_W-1:0]  pix_q;
   logic [CNT_W-1:0]  num_pix_q;
   logic [DATA_W-1:0] bias_q [N_GROUPS][N_adder_tree];

   logic [N_adder_tree*DATA_W-1:0] next_data;
   logic accept;
   logic out_fire;
   logic last_grp;
   logic last_beat;
   logic start_pass;

   // A beat may enter whenever the single output register is empty or emptying this cycle.
   assign bus.in_ready = (state_q == RUN) && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign out_fire     = bus.out_valid && bus.out_ready;
   assign last_grp     = (grp_q == GRP_W'(N_GROUPS - 1));
   assign last_beat    = last_grp && (pix_q == num_pix_q - 1'b1);
   assign start_pass   = (state_q == IDLE) && start && (num_pix != '0);

   for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
      bias_sat_lane u_lane (
         .sum_in  (bus.in_data[DATA_W*k +: DATA_W]),
         .bias    (bias_q[grp_q][k]),
         .relu_en (relu_en),
         .result  (next_data[DATA_W*k +: DATA_W])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (num_pix == '0)) begin
               done_d = 1'b1;
            end else if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept && last_beat) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_fire) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grp_q     <= '0;
         pix_q     <= '0;
         num_pix_q <= '0;
      end else if (start_pass) begin
         grp_q     <= '0;
         pix_q     <= '0;
         num_pix_q <= num_pix;
      end else if (accept) begin
         if (last_grp) begin
            grp_q <= '0;
            pix_q <= pix_q + 1'b1;
         end else begin
            grp_q <= grp_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_group <= '0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= next_data;
         bus.out_group <= grp_q;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

   // A write landing on the entry being read this cycle takes effect for the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int g = 0; g < N_GROUPS; g++) begin
            for (int k = 0; k < N_adder_tree; k++) begin
               bias_q[g][k] <= '0;
            end
         end
      end else if (cfg_we) begin
         bias_q[cfg_addr[ADDR_W-1:LANE_W]][cfg_addr[LANE_W-1:0]] <= cfg_data;
      end
   end

endmodule

// File: tb/tb_bias_add_bank.sv
// tb/tb_bias_add_bank.sv - self-checking bench for bias_add_bank
module tb_bias_add_bank;
   import bias_add_bank_pkg::*;

   localparam int BUS_W   = N_adder_tree * DATA_W;
   localparam int N_ENT   = N_GROUPS * N_adder_tree;
   localparam int MAX_POS = (1 << (DATA_W - 1)) - 1;
   localparam int MIN_NEG = -(1 << (DATA_W - 1));

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              cfg_we   = 1'b0;
   logic [ADDR_W-1:0] cfg_addr = '0;
   logic [DATA_W-1:0] cfg_data = '0;
   logic              relu_en  = 1'b0;
   logic [CNT_W-1:0]  num_pix  = '0;
   logic              start    = 1'b0;
   logic              done;

   bias_add_bank_if bif ();

   bias_add_bank dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .relu_en  (relu_en),
      .num_pix  (num_pix),
      .start    (start),
      .done     (done),
      .bus      (bif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] model_lane(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic relu);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > MAX_POS) s = MAX_POS;
      else if (s < MIN_NEG) s = MIN_NEG;
      if (relu && s < 0) s = 0;
      return s[DATA_W-1:0];
   endfunction

   function automatic logic [BUS_W-1:0] lanes_all(input logic [DATA_W-1:0] v);
      logic [BUS_W-1:0] d;
      for (int k = 0; k < N_adder_tree; k++) d[DATA_W*k +: DATA_W] = v;
      return d;
   endfunction

   // Model state: bias table, beat index within the pass, expected/captured beats.
   logic [DATA_W-1:0] mbias [N_ENT];
   int                model_beat = 0;
   logic [BUS_W-1:0]  exp_q [$];
   int                expg_q [$];
   logic [BUS_W-1:0]  cap_q [$];
   int                capg_q [$];
   logic [BUS_W-1:0]  stim_q [$];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ENT; i++) mbias[i] = '0;
      end else if (cfg_we) begin
         mbias[cfg_addr] = cfg_data;
      end
   end

   logic             prev_valid = 1'b0;
   logic             prev_ready = 1'b0;
   logic [BUS_W-1:0] prev_data  = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         expg_q.delete();
         cap_q.delete();
         capg_q.delete();
         model_beat = 0;
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", BUS_W'(bif.out_valid), BUS_W'(1));
            chk("hold_data", bif.out_data, prev_data);
         end
         if (bif.out_valid && !bif.out_ready)
            chk("stall_in_ready", BUS_W'(bif.in_ready), BUS_W'(0));
         if (bif.out_valid && bif.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", BUS_W'(1), BUS_W'(0));
            end else begin
               logic [BUS_W-1:0] e;
               int               eg;
               e  = exp_q.pop_front();
               eg = expg_q.pop_front();
               chk("out_data", bif.out_data, e);
               chk("out_group", BUS_W'(bif.out_group), BUS_W'(eg));
               cap_q.push_back(bif.out_data);
               capg_q.push_back(int'(bif.out_group));
            end
         end
         if (start) model_beat = 0;
         if (bif.in_valid && bif.in_ready) begin
            logic [BUS_W-1:0] e;
            int               g;
            g = model_beat % N_GROUPS;
            for (int k = 0; k < N_adder_tree; k++)
               e[DATA_W*k +: DATA_W] = model_lane(bif.in_data[DATA_W*k +: DATA_W],
                                                  mbias[g*N_adder_tree + k], relu_en);
            exp_q.push_back(e);
            expg_q.push_back(g);
            model_beat++;
         end
         prev_valid = bif.out_valid;
         prev_ready = bif.out_ready;
         prev_data  = bif.out_data;
      end
   end

   task automatic cfg_write(input int a, input int d);
      cfg_we   = 1'b1;
      cfg_addr = ADDR_W'(a);
      cfg_data = DATA_W'(d);
      @(posedge clk); #1;
      cfg_we   = 1'b0;
   endtask

   task automatic start_pass(input int n, input logic r);
      num_pix = CNT_W'(n);
      relu_en = r;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic send_beats();
      for (int i = 0; i < stim_q.size(); i++) begin
         bit took = 1'b0;
         bif.in_valid = 1'b1;
         bif.in_data  = stim_q[i];
         for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bif.in_ready) begin
               took = 1'b1;
               @(posedge clk); #1;
               break;
            end
            @(posedge clk); #1;
         end
         if (!took) begin
            chk("accept_timeout", BUS_W'(0), BUS_W'(1));
            break;
         end
      end
      bif.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk({nm, "_done_seen"}, BUS_W'(seen), BUS_W'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, BUS_W'(done), BUS_W'(0));
      @(posedge clk); #1;
      chk({nm, "_all_out"}, BUS_W'(exp_q.size()), BUS_W'(0));
   endtask

   initial begin
      logic [BUS_W-1:0] d;
      logic [BUS_W-1:0] tmp;

      bif.in_valid  = 1'b0;
      bif.in_data   = '0;
      bif.out_ready = 1'b1;

      #3;
      chk("rst_out_valid", BUS_W'(bif.out_valid), BUS_W'(0));
      chk("rst_in_ready", BUS_W'(bif.in_ready), BUS_W'(0));
      chk("rst_done", BUS_W'(done), BUS_W'(0));
      chk("rst_out_data", bif.out_data, '0);
      chk("rst_out_group", BUS_W'(bif.out_group), BUS_W'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic pass: bias[k]=k*4, all lanes 100.
      for (int i = 0; i < N_ENT; i++) cfg_write(i, i * 4);
      cap_q.delete(); capg_q.delete(); stim_q.delete();
      for (int i = 0; i < 4; i++) stim_q.push_back(lanes_all(DATA_W'(100)));
      start_pass(1, 1'b0);
      send_beats();
      wait_done("basic");
      chk("basic_count", BUS_W'(cap_q.size()), BUS_W'(4));
      for (int g = 0; g < 4 && g < cap_q.size(); g++) begin
         tmp = cap_q[g];
         chk("basic_group_lit", BUS_W'(capg_q[g]), BUS_W'(g));
         for (int k = 0; k < N_adder_tree; k++)
            chk("basic_lane_lit", BUS_W'(tmp[DATA_W*k +: DATA_W]), BUS_W'(100 + (g*16 + k) * 4));
      end

      // Empty pass: done pulses next cycle, no RUN.
      start_pass(0, 1'b0);
      @(negedge clk);
      chk("zero_done", BUS_W'(done), BUS_W'(1));
      chk("zero_in_ready", BUS_W'(bif.in_ready), BUS_W'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_done_clear", BUS_W'(done), BUS_W'(0));
      @(posedge clk); #1;

      // Saturation rails and ReLU.
      cfg_write(0, 1);
      cfg_write(1, -1);
      cfg_write(2, 10);
      cfg_write(3, -10);
      cap_q.delete(); capg_q.delete(); stim_q.delete();
      d = lanes_all('0);
      d[DATA_W*0 +: DATA_W] = 18'h1FFFF;
      d[DATA_W*1 +: DATA_W] = 18'h20000;
      stim_q.push_back(d);
      for (int i = 0; i < 3; i++) stim_q.push_back(lanes_all(DATA_W'(-7)));
      start_pass(1, 1'b0);
      send_beats();
      wait_done("sat");
      if (cap_q.size() > 0) begin
         tmp = cap_q[0];
         chk("sat_pos_lit", BUS_W'(tmp[DATA_W*0 +: DATA_W]), BUS_W'(18'h1FFFF));
         chk("sat_neg_lit", BUS_W'(tmp[DATA_W*1 +: DATA_W]), BUS_W'(18'h20000));
      end else chk("sat_count", BUS_W'(0), BUS_W'(4));

      cap_q.delete(); capg_q.delete(); stim_q.delete();
      d = lanes_all(DATA_W'(-3));
      d[DATA_W*2 +: DATA_W] = DATA_W'(-50);
      d[DATA_W*3 +: DATA_W] = DATA_W'(50);
      stim_q.push_back(d);
      for (int i = 0; i < 3; i++) stim_q.push_back(lanes_all(DATA_W'(-200)));
      start_pass(1, 1'b1);
      send_beats();
      wait_done("relu");
      if (cap_q.size() > 0) begin
         tmp = cap_q[0];
         chk("relu_neg_lit", BUS_W'(tmp[DATA_W*2 +: DATA_W]), BUS_W'(0));
         chk("relu_pos_lit", BUS_W'(tmp[DATA_W*3 +: DATA_W]), BUS_W'(40));
      end else chk("relu_count", BUS_W'(0), BUS_W'(4));

      // Back-pressure mid-pass.
      cap_q.delete(); capg_q.delete(); stim_q.delete();
      for (int i = 0; i < 12; i++) stim_q.push_back(lanes_all(DATA_W'(i * 1000 - 3000)));
      start_pass(3, 1'b0);
      fork
         send_beats();
         begin
            repeat (3) @(posedge clk);
            #1 bif.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 bif.out_ready = 1'b1;
         end
      join
      wait_done("stall");
      chk("stall_count", BUS_W'(cap_q.size()), BUS_W'(12));

      // Bias write colliding with the group-0 accept.
      cap_q.delete(); capg_q.delete(); stim_q.delete();
      for (int i = 0; i < 8; i++) stim_q.push_back(lanes_all(DATA_W'(5)));
      start_pass(2, 1'b0);
      fork
         send_beats();
         begin
            for (int i = 0; i < 50; i++) begin
               @(negedge clk);
               if (bif.in_valid && bif.in_ready) begin
                  #1;
                  cfg_we   = 1'b1;
                  cfg_addr = '0;
                  cfg_data = DATA_W'(777);
                  @(posedge clk); #1;
                  cfg_we   = 1'b0;
                  break;
               end
            end
         end
      join
      wait_done("wr_collide");
      if (cap_q.size() == 8) begin
         tmp = cap_q[0];
         chk("collide_old_lit", BUS_W'(tmp[DATA_W*0 +: DATA_W]), BUS_W'(6));
         chk("collide_lane1_lit", BUS_W'(tmp[DATA_W*1 +: DATA_W]), BUS_W'(4));
         tmp = cap_q[4];
         chk("collide_new_lit", BUS_W'(tmp[DATA_W*0 +: DATA_W]), BUS_W'(782));
      end else chk("collide_count", BUS_W'(cap_q.size()), BUS_W'(8));

      // Reset in the middle of a pass.
      stim_q.delete();
      for (int i = 0; i < 2; i++) stim_q.push_back(lanes_all(DATA_W'(9)));
      start_pass(2, 1'b0);
      send_beats();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", BUS_W'(bif.out_valid), BUS_W'(0));
      chk("midrst_in_ready", BUS_W'(bif.in_ready), BUS_W'(0));
      chk("midrst_done", BUS_W'(done), BUS_W'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      cap_q.delete(); capg_q.delete(); stim_q.delete();
      for (int i = 0; i < 4; i++) stim_q.push_back(lanes_all(DATA_W'(7)));
      start_pass(1, 1'b0);
      send_beats();
      wait_done("after_rst");
      if (cap_q.size() == 4) begin
         tmp = cap_q[3];
         chk("after_rst_bias0_lit", BUS_W'(tmp[DATA_W*5 +: DATA_W]), BUS_W'(7));
      end else chk("after_rst_count", BUS_W'(cap_q.size()), BUS_W'(4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
